// File: rtl/register_file_mp.sv
// Multi-port register file: two combinational read ports, two clocked write ports (B wins a
// same-address collision), optional write-to-read bypass and zero register, per-register busy bits.
module register_file_mp #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              bs_en,
  input  logic [ADDR_W-1:0] bs_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              ra_busy,
  output logic              rb_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic [1:0]        rd_busy;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  // Port B is applied after port A so it wins a collision; a busy-set overrides a same-edge clear
  // because it marks a newly issued producer.
  always_comb begin
    for (int n = 0; n < DEPTH; n++) begin
      regs_d[n] = regs_q[n];
      busy_d[n] = busy_q[n];
      if (wa_en && (wa_addr == ADDR_W'(n))) begin
        regs_d[n] = wa_data;
        busy_d[n] = 1'b0;
      end
      if (wb_en && (wb_addr == ADDR_W'(n))) begin
        regs_d[n] = wb_data;
        busy_d[n] = 1'b0;
      end
      if (bs_en && (bs_addr == ADDR_W'(n))) begin
        busy_d[n] = 1'b1;
      end
      if (ZERO_REG && (n == 0)) begin
        regs_d[n] = '0;
        busy_d[n] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < DEPTH; n++) begin
        regs_q[n] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int n = 0; n < DEPTH; n++) begin
        regs_q[n] <= regs_d[n];
      end
      busy_q <= busy_d;
    end
  end

  assign rd_addr[0] = ra_addr;
  assign rd_addr[1] = rb_addr;

  // Outputs are forced to zero during reset so the bypass path cannot leak write data.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd_a[p]   = wa_en && (wa_addr == rd_addr[p]);
      fwd_b[p]   = wb_en && (wb_addr == rd_addr[p]);
      rd_data[p] = regs_q[rd_addr[p]];
      rd_busy[p] = busy_q[rd_addr[p]];
      if (BYPASS) begin
        if (fwd_b[p]) begin
          rd_data[p] = wb_data;
        end else if (fwd_a[p]) begin
          rd_data[p] = wa_data;
        end
        if (fwd_a[p] || fwd_b[p]) begin
          rd_busy[p] = 1'b0;
        end
      end
      if (ZERO_REG && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
      if (rst) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign ra_data = rd_data[0];
  assign rb_data = rd_data[1];
  assign ra_busy = rd_busy[0];
  assign rb_busy = rd_busy[1];

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp over three builds: 4x4 bypass, 4x4 zero-reg without bypass,
// and 32x32 without bypass; expectations come from an array model of the register/busy rules.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: DATA_W=4 ADDR_W=2 BYPASS=1 ZERO_REG=0
  logic [1:0] ra0, rb0, waa0, wba0, bsa0;
  logic [3:0] wad0, wbd0, rda0, rdb0;
  logic       wae0, wbe0, bse0, rba0, rbb0;
  // instance 1: DATA_W=4 ADDR_W=2 BYPASS=0 ZERO_REG=1
  logic [1:0] ra1, rb1, waa1, wba1, bsa1;
  logic [3:0] wad1, wbd1, rda1, rdb1;
  logic       wae1, wbe1, bse1, rba1, rbb1;
  // instance 2: DATA_W=32 ADDR_W=5 BYPASS=0 ZERO_REG=0
  logic [4:0]  ra2, rb2, waa2, wba2, bsa2;
  logic [31:0] wad2, wbd2, rda2, rdb2;
  logic        wae2, wbe2, bse2, rba2, rbb2;

  register_file_mp #(.DATA_W(4), .ADDR_W(2), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ra_addr(ra0), .rb_addr(rb0),
    .wa_en(wae0), .wa_addr(waa0), .wa_data(wad0), .wb_en(wbe0), .wb_addr(wba0), .wb_data(wbd0),
    .bs_en(bse0), .bs_addr(bsa0), .ra_data(rda0), .rb_data(rdb0), .ra_busy(rba0), .rb_busy(rbb0));

  register_file_mp #(.DATA_W(4), .ADDR_W(2), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .ra_addr(ra1), .rb_addr(rb1),
    .wa_en(wae1), .wa_addr(waa1), .wa_data(wad1), .wb_en(wbe1), .wb_addr(wba1), .wb_data(wbd1),
    .bs_en(bse1), .bs_addr(bsa1), .ra_data(rda1), .rb_data(rdb1), .ra_busy(rba1), .rb_busy(rbb1));

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut2 (
    .clk(clk), .rst(rst), .ra_addr(ra2), .rb_addr(rb2),
    .wa_en(wae2), .wa_addr(waa2), .wa_data(wad2), .wb_en(wbe2), .wb_addr(wba2), .wb_data(wbd2),
    .bs_en(bse2), .bs_addr(bsa2), .ra_data(rda2), .rb_data(rdb2), .ra_busy(rba2), .rb_busy(rbb2));

  typedef struct {
    int unsigned ra, rb, waa, wad, wba, wbd, bsa;
    bit wae, wbe, bse;
  } stim_t;

  typedef struct {
    int          inst;
    string       tag;
    int unsigned da, db;
    bit          ba, bb;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned m_mem [3][32];
  bit          m_busy[3][32];

  function automatic int cfg_aw(input int i);
    return (i == 2) ? 5 : 2;
  endfunction
  function automatic int unsigned cfg_mask(input int i);
    return (i == 2) ? 32'hFFFF_FFFF : 32'hF;
  endfunction
  function automatic bit cfg_byp(input int i);
    return i == 0;
  endfunction
  function automatic bit cfg_zero(input int i);
    return i == 1;
  endfunction

  // Reference read: what a port at addr shows during the current cycle.
  function automatic void mread(input int i, input int unsigned addr, input stim_t s, input bit r,
                                output int unsigned d, output bit b);
    d = m_mem[i][addr];
    b = m_busy[i][addr];
    if (cfg_byp(i)) begin
      if (s.wbe && s.wba == addr) d = s.wbd;
      else if (s.wae && s.waa == addr) d = s.wad;
      if ((s.wbe && s.wba == addr) || (s.wae && s.waa == addr)) b = 1'b0;
    end
    if (cfg_zero(i) && addr == 0) begin
      d = 0;
      b = 1'b0;
    end
    if (r) begin
      d = 0;
      b = 1'b0;
    end
  endfunction

  function automatic void mupdate(input int i, input stim_t s, input bit r);
    if (r) begin
      for (int n = 0; n < 32; n++) begin
        m_mem[i][n]  = 0;
        m_busy[i][n] = 1'b0;
      end
      return;
    end
    if (s.wae) begin
      m_mem[i][s.waa]  = s.wad;
      m_busy[i][s.waa] = 1'b0;
    end
    if (s.wbe) begin
      m_mem[i][s.wba]  = s.wbd;
      m_busy[i][s.wba] = 1'b0;
    end
    if (s.bse) m_busy[i][s.bsa] = 1'b1;
    if (cfg_zero(i)) begin
      m_mem[i][0]  = 0;
      m_busy[i][0] = 1'b0;
    end
  endfunction

  function automatic stim_t rnd(input int i);
    stim_t s;
    int unsigned top;
    top   = (32'd1 << cfg_aw(i)) - 1;
    s.ra  = $urandom_range(top, 0);
    s.rb  = $urandom_range(top, 0);
    s.waa = $urandom_range(top, 0);
    s.wba = $urandom_range(top, 0);
    s.bsa = $urandom_range(top, 0);
    s.wad = $urandom & cfg_mask(i);
    s.wbd = $urandom & cfg_mask(i);
    s.wae = 1'($urandom_range(1, 0));
    s.wbe = 1'($urandom_range(1, 0));
    s.bse = 1'($urandom_range(1, 0));
    return s;
  endfunction

  task automatic drive(input int i, input stim_t s);
    case (i)
      0: begin
        ra0 = 2'(s.ra); rb0 = 2'(s.rb); waa0 = 2'(s.waa); wba0 = 2'(s.wba); bsa0 = 2'(s.bsa);
        wad0 = 4'(s.wad); wbd0 = 4'(s.wbd); wae0 = s.wae; wbe0 = s.wbe; bse0 = s.bse;
      end
      1: begin
        ra1 = 2'(s.ra); rb1 = 2'(s.rb); waa1 = 2'(s.waa); wba1 = 2'(s.wba); bsa1 = 2'(s.bsa);
        wad1 = 4'(s.wad); wbd1 = 4'(s.wbd); wae1 = s.wae; wbe1 = s.wbe; bse1 = s.bse;
      end
      default: begin
        ra2 = 5'(s.ra); rb2 = 5'(s.rb); waa2 = 5'(s.waa); wba2 = 5'(s.wba); bsa2 = 5'(s.bsa);
        wad2 = s.wad; wbd2 = s.wbd; wae2 = s.wae; wbe2 = s.wbe; bse2 = s.bse;
      end
    endcase
  endtask

  task automatic push_const(input int i, input string tag, input int unsigned da, input int unsigned db,
                            input bit ba, input bit bb);
    exp_t e;
    e.inst = i; e.tag = tag; e.da = da; e.db = db; e.ba = ba; e.bb = bb;
    q.push_back(e);
  endtask

  // One cycle: drive just after the edge, queue this cycle's expected reads, advance the model.
  task automatic step(input stim_t s0, input stim_t s1, input stim_t s2, input bit r, input string tag);
    stim_t s [3];
    exp_t  e;
    s[0] = s0; s[1] = s1; s[2] = s2;
    @(posedge clk);
    #1;
    rst = r;
    for (int i = 0; i < 3; i++) begin
      drive(i, s[i]);
      e.inst = i;
      e.tag  = tag;
      mread(i, s[i].ra, s[i], r, e.da, e.ba);
      mread(i, s[i].rb, s[i], r, e.db, e.bb);
      q.push_back(e);
      mupdate(i, s[i], r);
    end
  endtask

  function automatic void get_act(input int i, output int unsigned da, output int unsigned db,
                                  output bit ba, output bit bb);
    case (i)
      0:       begin da = 32'(rda0); db = 32'(rdb0); ba = rba0; bb = rbb0; end
      1:       begin da = 32'(rda1); db = 32'(rdb1); ba = rba1; bb = rbb1; end
      default: begin da = rda2;      db = rdb2;      ba = rba2; bb = rbb2; end
    endcase
  endfunction

  initial begin : monitor
    exp_t        e;
    int unsigned da, db;
    bit          ba, bb;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        get_act(e.inst, da, db, ba, bb);
        checks++;
        if (da !== e.da || db !== e.db || ba !== e.ba || bb !== e.bb) begin
          failures++;
          $display("FAIL %s inst%0d: got ra_data=%0h rb_data=%0h ra_busy=%0b rb_busy=%0b, expected %0h %0h %0b %0b",
                   e.tag, e.inst, da, db, ba, bb, e.da, e.db, e.ba, e.bb);
        end
      end
    end
  end

  initial begin : stimulus
    stim_t z, s0, s1, s2;
    z = '{default: 0};
    for (int i = 0; i < 3; i++) drive(i, z);
    for (int i = 0; i < 3; i++) mupdate(i, z, 1'b1);

    step(z, z, z, 1'b1, "reset");
    step(z, z, z, 1'b1, "reset");

    for (int a = 0; a < 4; a++) begin
      s0 = z; s0.wae = 1'b1; s0.waa = a; s0.wad = 15; s0.ra = a;
      s2 = z; s2.wae = 1'b1; s2.waa = a; s2.wad = 15; s2.ra = a;
      step(s0, s0, s2, 1'b0, "fill");
    end

    // reset raised between edges while a write and a busy-set are presented
    s0 = z; s0.ra = 1; s0.rb = 2; s0.wae = 1'b1; s0.waa = 1; s0.wad = 5; s0.bse = 1'b1; s0.bsa = 1;
    step(s0, s0, s0, 1'b1, "rst_async");
    push_const(0, "rst_zero", 0, 0, 1'b0, 1'b0);
    s0 = z; s0.ra = 1; s0.rb = 2;
    step(s0, s0, s0, 1'b0, "rst_cleared");
    push_const(0, "rst_cleared_c", 0, 0, 1'b0, 1'b0);

    s0 = z; s0.wae = 1'b1; s0.waa = 1; s0.wad = 5; s0.wbe = 1'b1; s0.wba = 2; s0.wbd = 10;
    step(s0, s0, z, 1'b0, "basic_wr");
    s0 = z; s0.ra = 1; s0.rb = 2;
    step(s0, s0, z, 1'b0, "basic_rd");
    push_const(0, "basic_rd_c", 5, 10, 1'b0, 1'b0);

    s0 = z; s0.wae = 1'b1; s0.waa = 3; s0.wad = 3; s0.wbe = 1'b1; s0.wba = 3; s0.wbd = 12; s0.ra = 3; s0.rb = 3;
    step(s0, s0, z, 1'b0, "collision");
    push_const(0, "coll_bypass", 12, 12, 1'b0, 1'b0);
    push_const(1, "coll_nobypass", 0, 0, 1'b0, 1'b0);
    s0 = z; s0.ra = 3; s0.rb = 3;
    step(s0, s0, z, 1'b0, "coll_after");
    push_const(0, "coll_after_byp", 12, 12, 1'b0, 1'b0);
    push_const(1, "coll_after_nobyp", 12, 12, 1'b0, 1'b0);

    s0 = z; s0.bse = 1'b1; s0.bsa = 2; s0.rb = 2;
    step(s0, s0, z, 1'b0, "busy_issue");
    s0 = z; s0.rb = 2;
    step(s0, s0, z, 1'b0, "busy_set");
    push_const(0, "busy_set_c", 0, 10, 1'b0, 1'b1);
    s0 = z; s0.wae = 1'b1; s0.waa = 2; s0.wad = 9; s0.bse = 1'b1; s0.bsa = 2; s0.rb = 2;
    step(s0, s0, z, 1'b0, "busy_wr_set");
    push_const(0, "busy_fwd", 0, 9, 1'b0, 1'b0);
    push_const(1, "busy_nofwd", 0, 10, 1'b0, 1'b1);
    s0 = z; s0.rb = 2;
    step(s0, s0, z, 1'b0, "busy_set_wins");
    push_const(0, "busy_set_wins_c", 0, 9, 1'b0, 1'b1);
    s0 = z; s0.wae = 1'b1; s0.waa = 2; s0.wad = 6; s0.rb = 2;
    step(s0, s0, z, 1'b0, "busy_wr");
    s0 = z; s0.rb = 2;
    step(s0, s0, z, 1'b0, "busy_clear");
    push_const(0, "busy_clear_c", 0, 6, 1'b0, 1'b0);

    s1 = z; s1.wae = 1'b1; s1.waa = 0; s1.wad = 7; s1.wbe = 1'b1; s1.wba = 0; s1.wbd = 7;
    s1.bse = 1'b1; s1.bsa = 0;
    step(z, s1, z, 1'b0, "zero_same");
    push_const(1, "zero_same_c", 0, 0, 1'b0, 1'b0);
    step(z, z, z, 1'b0, "zero_after");
    push_const(1, "zero_after_c", 0, 0, 1'b0, 1'b0);

    s2 = z; s2.wae = 1'b1; s2.waa = 31; s2.wad = 32'hDEAD_BEEF; s2.wbe = 1'b1; s2.wba = 0; s2.wbd = 1;
    step(z, z, s2, 1'b0, "wide_wr");
    s2 = z; s2.ra = 31; s2.rb = 0;
    step(z, z, s2, 1'b0, "wide_rd");
    push_const(2, "wide_rd_c", 32'hDEAD_BEEF, 1, 1'b0, 1'b0);

    repeat (400) begin
      step(rnd(0), rnd(1), rnd(2), ($urandom_range(49, 0) == 0), "random");
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
